// File: rtl/udp_tx_scheduler_if.sv
// Request/handshake bundle between udp_tx_scheduler (master) and the mac_top packet engine (slave).
// All signals live in the gmii_tx_clk domain.
interface udp_tx_scheduler_if;
  logic        mac_fifo_rd_en;
  logic        mac_send_end;
  logic        arp_found;
  logic        mac_not_exist;
  logic        udp_tx_req;
  logic        arp_request_req;
  logic [15:0] udp_send_data_length;
  logic [15:0] udp_dst_port;
  logic [15:0] identify_code;

  modport master (
    input  mac_fifo_rd_en,
    input  mac_send_end,
    input  arp_found,
    input  mac_not_exist,
    output udp_tx_req,
    output arp_request_req,
    output udp_send_data_length,
    output udp_dst_port,
    output identify_code
  );

  modport slave (
    output mac_fifo_rd_en,
    output mac_send_end,
    output arp_found,
    output mac_not_exist,
    input  udp_tx_req,
    input  arp_request_req,
    input  udp_send_data_length,
    input  udp_dst_port,
    input  identify_code
  );
endinterface

// File: rtl/udp_tx_scheduler.sv
// UDP transmit scheduler: resolves the peer via ARP, then round-robins full-payload channel FIFOs.
// Build option SYNC_GATE_EN: when defined, packet scheduling waits for a frame-sync edge.
module udp_tx_scheduler #(
  parameter int          CH_NUM        = 2,
  parameter int          CNT_W         = 11,
  parameter int          PKT_LEN       = 1024,
  parameter int          IDLE_WAIT     = 1250000,
  parameter int          ARP_TIMEOUT   = 125000000,
  parameter int          FIFO_TIMEOUT  = 125000000,
  parameter int          ARP_RETRY_MAX = 8,
  parameter logic [15:0] PORT_BASE     = 16'h1f90,
  localparam int         CHW           = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                    gmii_tx_clk,
  input  logic                    rst,
  input  logic                    sync_in,
  input  logic [CH_NUM*CNT_W-1:0] fifo_data_count,
  output logic [CH_NUM-1:0]       fifo_rd_en,
  output logic [CHW-1:0]          cur_ch,
  output logic                    arp_fail,
  output logic                    busy,
  udp_tx_scheduler_if.master      mac
);

  localparam int          RETRY_W   = $clog2(ARP_RETRY_MAX + 1);
  localparam logic [31:0] IDLE_LAST = 32'(IDLE_WAIT - 1);
  localparam logic [31:0] ARP_LAST  = 32'(ARP_TIMEOUT - 1);
  localparam logic [31:0] FIFO_LAST = 32'(FIFO_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARP_REQ,
    S_ARP_SEND,
    S_ARP_WAIT,
    S_FAIL,
    S_WAIT_SYNC,
    S_SELECT,
    S_GEN_REQ,
    S_SEND,
    S_CHECK_ARP
  } state_t;

  state_t               state_reg, state_next;
  logic [31:0]          timer_reg, timer_next;
  logic                 timer_clr;
  logic                 timer_run;
  logic [RETRY_W-1:0]   retry_reg, retry_next;
  logic [CHW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [CHW-1:0]       cur_ch_reg, cur_ch_next;
  logic [15:0]          port_reg, port_next;
  logic [15:0]          id_reg, id_next;
  logic [15:0]          seq_reg, seq_next;
  logic                 clr_pend_reg, clr_pend_next;
  logic [2:0]           sync_ff_reg;
  logic                 sync_pe_reg;
  logic [CH_NUM-1:0]    fifo_rd_en_reg, fifo_rd_en_next;
  logic [CH_NUM-1:0]    elig;
  logic                 pick_valid;
  logic [CHW-1:0]       pick_ch;
  logic [CHW:0]         idx_w;
  logic [CHW-1:0]       idx_c;

  // Per-channel eligibility and read-strobe steering.
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    assign elig[gi]            = fifo_data_count[gi*CNT_W +: CNT_W] >= CNT_W'(PKT_LEN);
    assign fifo_rd_en_next[gi] = mac.mac_fifo_rd_en && (cur_ch_reg == CHW'(gi));
  end

  // Frame sync: two synchroniser flops, one edge flop, then a registered rising-edge pulse.
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      sync_ff_reg <= '0;
      sync_pe_reg <= 1'b0;
    end else begin
      sync_ff_reg <= {sync_ff_reg[1:0], sync_in};
      sync_pe_reg <= sync_ff_reg[1] & ~sync_ff_reg[2];
    end
  end

  // Round-robin search starting one past the last served channel.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    idx_w      = '0;
    idx_c      = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx_w = {1'b0, rr_ptr_reg} + (CHW+1)'(i);
      if (idx_w >= (CHW+1)'(CH_NUM)) begin
        idx_w = idx_w - (CHW+1)'(CH_NUM);
      end
      idx_c = idx_w[CHW-1:0];
      if (!pick_valid && elig[idx_c]) begin
        pick_valid = 1'b1;
        pick_ch    = idx_c;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    retry_next    = retry_reg;
    rr_ptr_next   = rr_ptr_reg;
    cur_ch_next   = cur_ch_reg;
    port_next     = port_reg;
    id_next       = id_reg;
    seq_next      = seq_reg;
    clr_pend_next = clr_pend_reg | sync_pe_reg;
    timer_clr     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (timer_reg == IDLE_LAST) state_next = S_ARP_REQ;
      end
      S_ARP_REQ: begin
        retry_next = retry_reg + RETRY_W'(1);
        state_next = S_ARP_SEND;
      end
      S_ARP_SEND: begin
        if (mac.mac_send_end) state_next = S_ARP_WAIT;
      end
      S_ARP_WAIT: begin
        if (mac.arp_found) begin
          retry_next = '0;
`ifdef SYNC_GATE_EN
          state_next = S_WAIT_SYNC;
`else
          state_next = S_SELECT;
`endif
        end else if (timer_reg == ARP_LAST) begin
          state_next = (retry_reg == RETRY_W'(ARP_RETRY_MAX)) ? S_FAIL : S_ARP_REQ;
        end
      end
      S_FAIL: begin
        state_next = S_FAIL;
      end
      S_WAIT_SYNC: begin
`ifdef SYNC_GATE_EN
        if (sync_pe_reg) state_next = S_SELECT;
`else
        state_next = S_SELECT;
`endif
      end
      S_SELECT: begin
        if (pick_valid) begin
          cur_ch_next = pick_ch;
          rr_ptr_next = pick_ch;
          port_next   = PORT_BASE + 16'(pick_ch);
          state_next  = S_GEN_REQ;
        end else if (timer_reg == FIFO_LAST) begin
`ifdef SYNC_GATE_EN
          state_next = S_WAIT_SYNC;
`else
          timer_clr  = 1'b1;
`endif
        end
      end
      S_GEN_REQ: begin
        // A pending frame restart numbers this packet 0; a sync edge landing now re-arms it.
        if (clr_pend_reg) begin
          id_next  = 16'd0;
          seq_next = 16'd1;
        end else begin
          id_next  = seq_reg;
          seq_next = seq_reg + 16'd1;
        end
        clr_pend_next = sync_pe_reg;
        state_next    = S_SEND;
      end
      S_SEND: begin
        if (mac.mac_send_end) state_next = S_CHECK_ARP;
      end
      S_CHECK_ARP: begin
        state_next = mac.mac_not_exist ? S_ARP_REQ : S_SELECT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign timer_run  = (state_reg == S_IDLE) || (state_reg == S_ARP_WAIT) || (state_reg == S_SELECT);
  assign timer_next = (!timer_run || timer_clr || (state_next != state_reg)) ? 32'd0 : timer_reg + 32'd1;

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      timer_reg      <= '0;
      retry_reg      <= '0;
      rr_ptr_reg     <= CHW'(CH_NUM - 1);
      cur_ch_reg     <= '0;
      port_reg       <= PORT_BASE;
      id_reg         <= '0;
      seq_reg        <= '0;
      clr_pend_reg   <= 1'b0;
      fifo_rd_en_reg <= '0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      retry_reg      <= retry_next;
      rr_ptr_reg     <= rr_ptr_next;
      cur_ch_reg     <= cur_ch_next;
      port_reg       <= port_next;
      id_reg         <= id_next;
      seq_reg        <= seq_next;
      clr_pend_reg   <= clr_pend_next;
      fifo_rd_en_reg <= fifo_rd_en_next;
    end
  end

  assign mac.udp_tx_req           = (state_reg == S_GEN_REQ);
  assign mac.arp_request_req      = (state_reg == S_ARP_REQ);
  assign mac.udp_send_data_length = 16'(PKT_LEN);
  assign mac.udp_dst_port         = port_reg;
  assign mac.identify_code        = id_reg;
  assign fifo_rd_en               = fifo_rd_en_reg;
  assign cur_ch                   = cur_ch_reg;
  assign arp_fail                 = (state_reg == S_FAIL);
  assign busy                     = (state_reg == S_ARP_SEND) || (state_reg == S_SEND);

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler: ARP failure, round-robin service, sequence restart,
// re-ARP and FIFO starvation, with a scoreboard of expected packets.
module tb_udp_tx_scheduler;
  localparam int          CH_NUM        = 2;
  localparam int          CNT_W         = 11;
  localparam int          PKT_LEN       = 1024;
  localparam int          IDLE_WAIT     = 16;
  localparam int          ARP_TIMEOUT   = 100;
  localparam int          FIFO_TIMEOUT  = 50;
  localparam int          ARP_RETRY_MAX = 3;
  localparam logic [15:0] PORT_BASE     = 16'h1f90;
  localparam int          CHW           = 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    sync_in;
  logic [CH_NUM*CNT_W-1:0] fifo_data_count;
  logic [CH_NUM-1:0]       fifo_rd_en;
  logic [CHW-1:0]          cur_ch;
  logic                    arp_fail;
  logic                    busy;

  udp_tx_scheduler_if mif();

  udp_tx_scheduler #(
    .CH_NUM(CH_NUM), .CNT_W(CNT_W), .PKT_LEN(PKT_LEN), .IDLE_WAIT(IDLE_WAIT),
    .ARP_TIMEOUT(ARP_TIMEOUT), .FIFO_TIMEOUT(FIFO_TIMEOUT),
    .ARP_RETRY_MAX(ARP_RETRY_MAX), .PORT_BASE(PORT_BASE)
  ) dut (
    .gmii_tx_clk(clk),
    .rst(rst),
    .sync_in(sync_in),
    .fifo_data_count(fifo_data_count),
    .fifo_rd_en(fifo_rd_en),
    .cur_ch(cur_ch),
    .arp_fail(arp_fail),
    .busy(busy),
    .mac(mif)
  );

  always #4 clk = ~clk;

  typedef struct {
    int          ch;
    logic [15:0] port;
    logic [15:0] id;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pkt_num  = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_counts(input int c0, input int c1);
    fifo_data_count = {CNT_W'(c1), CNT_W'(c0)};
  endtask

  task automatic push_exp(input int ch, input int id);
    exp_t e;
    e.ch   = ch;
    e.port = PORT_BASE + 16'(ch);
    e.id   = 16'(id);
    sb_q.push_back(e);
  endtask

  task automatic end_send();
    mif.mac_send_end = 1'b1;
    @(negedge clk);
    mif.mac_send_end = 1'b0;
  endtask

  task automatic pulse_found();
    mif.arp_found = 1'b1;
    @(negedge clk);
    mif.arp_found = 1'b0;
  endtask

  task automatic wait_arp_req(output int n);
    n = 0;
    while (mif.arp_request_req !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_tx(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mif.udp_tx_req === 1'b1) seen++;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(3);
    check("rst_udp_tx_req", mif.udp_tx_req, 1'b0);
    check("rst_arp_req", mif.arp_request_req, 1'b0);
    check("rst_len", mif.udp_send_data_length, 16'd1024);
    check("rst_port", mif.udp_dst_port, 16'h1f90);
    check("rst_id", mif.identify_code, 16'd0);
    check("rst_cur_ch", cur_ch, 1'b0);
    check("rst_arp_fail", arp_fail, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 2'b00);
    rst = 1'b0;
  endtask

  // Waits for udp_tx_req, compares against the oldest expectation, exercises the read strobe.
  // Leaves the DUT in SEND.
  task automatic serve_packet(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (mif.udp_tx_req !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, mif.udp_tx_req, 1'b1);
    checks++;
    assert (sb_q.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb_underflow observed=request expected=none", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      pkt_num++;
      $display("pkt %0d %s: ch=%0d port=%h id=%0d (expect ch=%0d port=%h id=%0d)",
               pkt_num, tag, cur_ch, mif.udp_dst_port, mif.identify_code + 16'd0,
               e.ch, e.port, e.id);
      check({tag, "_cur_ch"}, cur_ch, e.ch);
      check({tag, "_port"}, mif.udp_dst_port, e.port);
      @(negedge clk);
      check({tag, "_id"}, mif.identify_code, e.id);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_req_1cyc"}, mif.udp_tx_req, 1'b0);
      mif.mac_fifo_rd_en = 1'b1;
      @(negedge clk);
      check({tag, "_rd_en"}, fifo_rd_en, 2'b01 << e.ch);
      mif.mac_fifo_rd_en = 1'b0;
      @(negedge clk);
      check({tag, "_rd_en_off"}, fifo_rd_en, 2'b00);
    end
  endtask

  initial begin
    int n;
    int seen;
    rst                 = 1'b1;
    sync_in             = 1'b0;
    fifo_data_count     = '0;
    mif.mac_fifo_rd_en  = 1'b0;
    mif.mac_send_end    = 1'b0;
    mif.arp_found       = 1'b0;
    mif.mac_not_exist   = 1'b0;

    // ARP never answered: three requests, then permanent failure.
    apply_reset();
    wait_arp_req(n);
    check("arp1_latency", n, IDLE_WAIT);
    for (int r = 2; r <= ARP_RETRY_MAX; r++) begin
      tick(1);
      check("arp_send_busy", busy, 1'b1);
      end_send();
      check("arp_wait_busy", busy, 1'b0);
      wait_arp_req(n);
      check("arp_retry_latency", n, ARP_TIMEOUT);
    end
    tick(1);
    end_send();
    tick(ARP_TIMEOUT - 1);
    check("fail_not_yet", arp_fail, 1'b0);
    tick(1);
    check("fail_set", arp_fail, 1'b1);
    set_counts(1024, 1024);
    pulse_found();
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mif.arp_request_req === 1'b1 || mif.udp_tx_req === 1'b1) seen++;
    end
    check("fail_no_requests", seen, 0);
    check("fail_sticky", arp_fail, 1'b1);

    // ARP success, both channels full: alternating service.
    apply_reset();
    wait_arp_req(n);
    check("arp_ok_latency", n, IDLE_WAIT);
    tick(1);
    end_send();
    tick(5);
    pulse_found();
    push_exp(0, 0);
    push_exp(1, 1);
    push_exp(0, 2);
    push_exp(1, 3);
`ifdef SYNC_GATE_EN
    sync_in = 1'b1;
`endif
    serve_packet("rr0");
    sync_in = 1'b0;
    end_send();
    serve_packet("rr1");
    end_send();
    serve_packet("rr2");
    end_send();
    serve_packet("rr3");

    // Only channel 1 eligible; 1023 sits one below the threshold.
    set_counts(1023, 1024);
    push_exp(1, 4);
    push_exp(1, 5);
    end_send();
    serve_packet("only1_a");
    end_send();
    serve_packet("only1_b");

    // Sync edge mid-packet must not disturb the in-flight sequence number.
    sync_in = 1'b1;
    tick(6);
    check("id_hold_a", mif.identify_code, 16'd5);
    sync_in = 1'b0;
    tick(2);
    check("id_hold_b", mif.identify_code, 16'd5);
    push_exp(1, 0);
    push_exp(1, 1);
    end_send();
    serve_packet("restart0");
    end_send();
    serve_packet("restart1");

    // Peer lost after a packet: immediate re-ARP, no traffic until it resolves.
    mif.mac_not_exist = 1'b1;
    end_send();
    check("check_arp_no_req", mif.arp_request_req, 1'b0);
    tick(1);
    check("rearp_req", mif.arp_request_req, 1'b1);
    mif.mac_not_exist = 1'b0;
    tick(1);
    end_send();
    count_tx(30, seen);
    check("rearp_no_tx", seen, 0);
`ifdef SYNC_GATE_EN
    push_exp(1, 0);
    pulse_found();
    sync_in = 1'b1;
`else
    push_exp(1, 2);
    pulse_found();
`endif
    serve_packet("after_rearp");
    sync_in = 1'b0;

    // Starved FIFOs in SELECT.
    set_counts(0, 0);
    end_send();
`ifdef SYNC_GATE_EN
    count_tx(FIFO_TIMEOUT + 1, seen);
    check("starve_no_tx", seen, 0);
    set_counts(1024, 0);
    count_tx(20, seen);
    check("wait_sync_hold", seen, 0);
    push_exp(0, 0);
    sync_in = 1'b1;
    serve_packet("after_timeout");
    sync_in = 1'b0;
`else
    count_tx(2 * FIFO_TIMEOUT + 20, seen);
    check("starve_no_tx", seen, 0);
    set_counts(1024, 0);
    push_exp(0, 3);
    tick(1);
    check("req_within_1", mif.udp_tx_req, 1'b1);
    serve_packet("after_starve");
`endif
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
